// File: rtl/fibonacci_ctrl.sv
// -----------------------------------------------------------------------------
// fibonacci_ctrl
//
// Control FSM that sequences the fibonacci datapath (reg1/reg2/regN/counter).
// Once a start is accepted it loads the seeds for one cycle, then runs exactly
// N iterations, and then reports completion with a one-cycle done pulse.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   request to begin; only looked at in IDLE
//   abort        in   cancel LOAD/RUN, back to IDLE with no done pulse
//   N            in   iteration count, captured when start is accepted
//   load_init    out  datapath selects the initial seeds into reg1/reg2
//   enable_reg1  out  reg1 write enable
//   enable_reg2  out  reg2 write enable
//   enable_regN  out  N register write enable
//   enable_count out  iteration counter enable
//   busy         out  high in LOAD and RUN
//   done         out  one-cycle completion pulse
//   term_idx     out  iteration currently being computed (1..N)
// -----------------------------------------------------------------------------
module fibonacci_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] N,
    output logic             load_init,
    output logic             enable_reg1,
    output logic             enable_reg2,
    output logic             enable_regN,
    output logic             enable_count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] term_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_reg_q, n_reg_d;
    logic [WIDTH-1:0] term_idx_q, term_idx_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_reg_q    <= '0;
            term_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            n_reg_q    <= n_reg_d;
            term_idx_q <= term_idx_d;
        end
    end

    // Next-state logic. abort outranks everything except reset, but only
    // matters while the datapath is actually being driven (LOAD/RUN).
    always_comb begin
        state_d    = state_q;
        n_reg_d    = n_reg_q;
        term_idx_d = term_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (N != '0) begin
                        n_reg_d = N;
                        state_d = S_LOAD;
                    end else begin
                        // Nothing to compute: report completion without
                        // ever touching the datapath.
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    term_idx_d = WIDTH'(1);
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (term_idx_q == n_reg_q) begin
                    // Equality stop: term_idx never advances past n_reg, so
                    // N = 2^WIDTH-1 finishes without wrapping.
                    state_d = S_DONE;
                end else begin
                    term_idx_d = term_idx_q + WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from the registered state only.
    always_comb begin
        load_init    = 1'b0;
        enable_reg1  = 1'b0;
        enable_reg2  = 1'b0;
        enable_regN  = 1'b0;
        enable_count = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                load_init   = 1'b1;
                enable_reg1 = 1'b1;
                enable_reg2 = 1'b1;
                enable_regN = 1'b1;
                busy        = 1'b1;
            end
            S_RUN: begin
                enable_reg1  = 1'b1;
                enable_reg2  = 1'b1;
                enable_count = 1'b1;
                busy         = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign term_idx = term_idx_q;

endmodule

// File: tb/tb_fibonacci_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fibonacci_ctrl
//
// Reference model: an accepted start expands into a schedule of expected
// output vectors (one LOAD, N RUN vectors with term 1..N, one DONE). Each
// cycle pops the next vector; an empty schedule means idle. abort flushes the
// schedule while busy, reset flushes it and zeroes term_idx.
// -----------------------------------------------------------------------------
module tb_fibonacci_ctrl;

    localparam int W = 8;

    // ctl bits: {load_init, enable_reg1, enable_reg2, enable_regN, enable_count, busy, done}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_LOAD = 7'b1111010;
    localparam logic [6:0] C_RUN  = 7'b0110110;
    localparam logic [6:0] C_DONE = 7'b0000001;

    typedef struct packed {
        logic [6:0]   ctl;
        logic [W-1:0] term;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset, start, abort;
    logic [W-1:0] N;
    logic         load_init, enable_reg1, enable_reg2, enable_regN;
    logic         enable_count, busy, done;
    logic [W-1:0] term_idx;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sched[$];
    exp_t cur;

    fibonacci_ctrl #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .N(N),
        .load_init(load_init), .enable_reg1(enable_reg1), .enable_reg2(enable_reg2),
        .enable_regN(enable_regN), .enable_count(enable_count), .busy(busy),
        .done(done), .term_idx(term_idx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance the reference by one clock given the inputs seen at that edge.
    task automatic model(input logic rs, input logic st, input logic ab, input logic [W-1:0] n);
        if (rs) begin
            sched.delete();
            cur = '{ctl: C_IDLE, term: '0};
        end else if (ab && cur.ctl[1]) begin
            sched.delete();
            cur.ctl = C_IDLE;
        end else if (sched.size() > 0) begin
            cur = sched.pop_front();
        end else if (st && cur.ctl == C_IDLE) begin
            if (n == 0) begin
                cur.ctl = C_DONE;
            end else begin
                cur.ctl = C_LOAD;
                for (int i = 1; i <= int'(n); i++) sched.push_back('{ctl: C_RUN, term: W'(i)});
                sched.push_back('{ctl: C_DONE, term: n});
            end
        end else begin
            cur.ctl = C_IDLE;
        end
    endtask

    task automatic step(input logic rs, input logic st, input logic ab, input logic [W-1:0] n);
        reset = rs; start = st; abort = ab; N = n;
        model(rs, st, ab, n);
        @(posedge clock);
        #1;
        chk("ctl", {25'd0, load_init, enable_reg1, enable_reg2, enable_regN,
                    enable_count, busy, done}, {25'd0, cur.ctl});
        chk("term_idx", {24'd0, term_idx}, {24'd0, cur.term});
    endtask

    int runs;
    int dones;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; N = '0;
        cur = '{ctl: C_IDLE, term: '0};

        // Reset held with start asserted: must stay idle.
        step(1, 1, 0, 4);
        step(1, 1, 0, 4);
        step(0, 0, 0, 4);
        step(0, 0, 0, 4);

        // Nominal N=4.
        step(0, 1, 0, 4);
        repeat (7) step(0, 0, 0, 9);
        chk("n4_term_final", {24'd0, term_idx}, 32'd4);

        // N=0: done the cycle after start, no enables.
        step(0, 1, 0, 0);
        chk("n0_done", {31'd0, done}, 32'd1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // N=1.
        step(0, 1, 0, 1);
        repeat (4) step(0, 0, 0, 0);

        // Abort at term_idx=3 with N=10.
        step(0, 1, 0, 10);
        repeat (3) step(0, 0, 0, 10);
        step(0, 0, 1, 10);
        chk("abort_term", {24'd0, term_idx}, 32'd3);
        repeat (2) step(0, 0, 0, 10);

        // Start with N=7 mid-RUN is ignored; run still takes 10 iterations.
        runs = 0;
        step(0, 1, 0, 10);
        for (int i = 0; i < 14; i++) begin
            step(0, (i == 4), (i == 13), (i == 4) ? 8'd7 : 8'd10);
            if (enable_count) runs++;
        end
        chk("ignored_start_runs", runs, 32'd10);

        // Reset mid-RUN at term_idx=2, then N=2 completes.
        step(0, 1, 0, 6);
        step(0, 0, 0, 6);
        step(0, 0, 0, 6);
        step(1, 0, 0, 6);
        chk("midrun_reset_term", {24'd0, term_idx}, 32'd0);
        step(0, 1, 0, 2);
        repeat (5) step(0, 0, 0, 2);

        // Max N: 255 iterations, no wrap.
        runs = 0;
        step(0, 1, 0, 255);
        for (int i = 0; i < 258; i++) begin
            step(0, 0, 0, 0);
            if (enable_count) runs++;
        end
        chk("maxn_runs", runs, 32'd255);
        chk("maxn_term", {24'd0, term_idx}, 32'd255);

        // Start held high: back-to-back runs with one idle cycle between.
        dones = 0;
        for (int i = 0; i < 18; i++) begin
            step(0, 1, 0, 3);
            if (done) dones++;
        end
        chk("b2b_dones", dones, 32'd3);
        repeat (6) step(0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 127) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 15) == 0) ? W'($urandom) : W'($urandom_range(0, 12)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fibonacci_ctrl.md
Name: fibonacci_ctrl

Overview:
Control FSM that sequences the fibonacci datapath (the regs/counter/comparator block producing FIB_SAIDA). Accepts a start pulse and a term count N, then drives enable_reg1, enable_reg2, enable_regN and enable_count for exactly N iterations. Signals completion with a one-cycle done pulse. Sits directly upstream of the datapath and replaces the hand-driven enables currently tied high.

Parameters:
WIDTH, 8, width of N and term_idx (matches datapath N/FIB_SAIDA width)

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a computation; sampled only in IDLE
abort  input  1  cancel in-progress computation; return to IDLE without done
N  input  WIDTH  number of iterations to run; captured on accepted start
load_init  output  1  datapath selects initial seeds (n1/n2) into reg1/reg2
enable_reg1  output  1  write enable, datapath reg1
enable_reg2  output  1  write enable, datapath reg2
enable_regN  output  1  write enable, datapath N register
enable_count  output  1  datapath iteration counter enable
busy  output  1  high in LOAD and RUN
done  output  1  one-cycle completion pulse
term_idx  output  WIDTH  iteration number currently being computed

Behaviour:
- Reset: synchronous, active-high, one clock cycle. State=IDLE; n_reg=0; term_idx=0; all outputs 0.
- Outputs are a Moore decode of the registered state (no combinational path from inputs to outputs), except term_idx, which is its own register.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - All enables, busy and done are 0. term_idx holds its last value.
  - start=1 and N!=0: capture n_reg<=N, go to LOAD.
  - start=1 and N==0: go to DONE directly. No enables are ever asserted.
- LOAD (exactly 1 cycle):
  - load_init=1, enable_reg1=1, enable_reg2=1, enable_regN=1, enable_count=0, busy=1.
  - term_idx<=1 at the exit edge.
  - Next state: RUN.
- RUN:
  - enable_reg1=1, enable_reg2=1, enable_count=1, load_init=0, enable_regN=0, busy=1.
  - term_idx shows the current iteration, 1..n_reg.
  - If term_idx==n_reg: go to DONE, term_idx holds.
  - Otherwise: term_idx<=term_idx+1, stay in RUN.
  - RUN therefore lasts exactly n_reg cycles.
- DONE (exactly 1 cycle):
  - done=1, busy=0, all enables 0, term_idx holds n_reg.
  - Next state: IDLE.
- Latency: start accepted at edge k →
  - LOAD in cycle k..k+1
  - RUN for N cycles
  - done high in the (N+2)th cycle after k
  - back in IDLE one cycle later
  - Back-to-back start accepted the first cycle IDLE is observed.
- Priority: reset > abort > start.
- abort in LOAD or RUN: next state IDLE, no done pulse, term_idx holds its partial value.
- abort in IDLE or DONE: no effect (DONE still completes to IDLE with done=1 that cycle).
- start outside IDLE is ignored. N changes outside accepted start are ignored (n_reg is frozen).
- Reset asserted mid-LOAD/RUN/DONE: IDLE on that edge, all outputs 0 the following cycle, term_idx=0.
- Width rules: N=2^WIDTH-1 is legal. The term_idx compare is WIDTH-bit equality, so term_idx never wraps.

Test Plan:
- Reset: assert reset 2 cycles with start=1, N=4 → all outputs 0, term_idx=0, state stays IDLE. Deassert reset → no spurious LOAD.
- Nominal N=4: pulse start → 1 cycle load_init/enable_reg1/enable_reg2/enable_regN=1, then 4 cycles enable_count=1 with term_idx=1,2,3,4, then done=1 for exactly one cycle, busy low, IDLE.
- N=0 and N=1:
  - N=0 → done pulses the cycle after start, with no enable ever high.
  - N=1 → LOAD, 1 RUN cycle (term_idx=1), then done.
- Abort and ignored start: N=10, assert abort when term_idx=3 → IDLE next cycle, no done, term_idx=3. Pulse start with N=7 mid-RUN → ignored; the run completes with 10 iterations.
- Reset mid-RUN: N=6, assert reset at term_idx=2 → next cycle all outputs 0, term_idx=0. A subsequent start with N=2 completes normally.
- Max N and back-to-back:
  - N=255 → exactly 255 RUN cycles, term_idx ends at 255 without wrap.
  - start held high continuously → a new LOAD begins the cycle after DONE→IDLE, one IDLE cycle between runs.
